// File: rtl/multi_input_conditioner.sv
// Per-channel synchronizer, stability debouncer and edge/event flags for raw asynchronous inputs.
// A new level is accepted only after sync_out disagrees with conditioned for WAIT_CYCLES consecutive edges.
module multi_input_conditioner #(
    parameter int                  CHANNELS    = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  WAIT_CYCLES = 3,
    parameter logic [CHANNELS-1:0] RESET_LEVEL = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] event_pending,
    input  logic [CHANNELS-1:0] event_clear
);

    localparam int              CNT_W  = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(WAIT_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  sync_out;
    logic [CNT_W-1:0]                     cnt [CHANNELS];
    logic [CHANNELS-1:0]                  differ;
    logic [CHANNELS-1:0]                  at_tc;
    logic [CHANNELS-1:0]                  accept;

    // Stage 0 captures the raw input; the top stage is the only one the debouncer looks at.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisysignal};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign differ   = sync_out ^ conditioned;

    always_comb begin
        at_tc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            at_tc[i] = (cnt[i] == CNT_TC);
        end
    end

    assign accept = differ & at_tc;

    // Pulses are registered alongside conditioned so they coincide with the first cycle of the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conditioned   <= RESET_LEVEL;
            positiveedge  <= '0;
            negativeedge  <= '0;
            event_pending <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            conditioned   <= (conditioned & ~accept) | (sync_out & accept);
            positiveedge  <= accept & sync_out;
            negativeedge  <= accept & ~sync_out;
            event_pending <= accept | (event_pending & ~event_clear);
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= (differ[i] && !at_tc[i]) ? cnt[i] + 1'b1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Bench for multi_input_conditioner: directed scenarios plus random traffic against a window-based model.
// A second instance covers the single-channel, deep-sync, zero-wait configuration.
module tb_multi_input_conditioner;

    localparam int         CH    = 4;
    localparam int         SYNC  = 2;
    localparam int         WAIT  = 3;
    localparam logic [3:0] RLVL  = 4'b0000;

    logic       clk;
    logic       reset_n;
    logic [3:0] a_in, a_clr, a_cond, a_pos, a_neg, a_pend;
    logic [0:0] b_in, b_clr, b_cond, b_pos, b_neg, b_pend;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [3:0] m_cond, m_pos, m_neg, m_pend;
    logic [3:0] in_hist [$];
    logic [3:0] diff_hist [$];
    int         last_acc [CH];
    int         e;

    multi_input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .WAIT_CYCLES(WAIT), .RESET_LEVEL(RLVL)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .noisysignal(a_in), .conditioned(a_cond),
        .positiveedge(a_pos), .negativeedge(a_neg), .event_pending(a_pend), .event_clear(a_clr)
    );

    multi_input_conditioner #(
        .CHANNELS(1), .SYNC_STAGES(3), .WAIT_CYCLES(1), .RESET_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .noisysignal(b_in), .conditioned(b_cond),
        .positiveedge(b_pos), .negativeedge(b_neg), .event_pending(b_pend), .event_clear(b_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h time=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cond = RLVL;
        m_pos  = '0;
        m_neg  = '0;
        m_pend = '0;
        in_hist.delete();
        diff_hist.delete();
        for (int i = 0; i < CH; i++) last_acc[i] = -1;
        e = 0;
    endtask

    // Accept on edge e when the last WAIT edges, all after the previous accept, saw sync != conditioned.
    task automatic model_edge(input logic [3:0] nin, input logic [3:0] clr);
        logic [3:0] sb, acc;
        in_hist.push_back(nin);
        sb = (e >= SYNC) ? in_hist[e - SYNC] : RLVL;
        diff_hist.push_back(sb ^ m_cond);
        acc = '0;
        for (int i = 0; i < CH; i++) begin
            acc[i] = (e - WAIT + 1 > last_acc[i]);
            for (int j = 0; j < WAIT; j++) begin
                if (acc[i] && diff_hist[e - j][i] == 1'b0) acc[i] = 1'b0;
            end
            if (acc[i]) last_acc[i] = e;
        end
        m_pos  = acc & sb;
        m_neg  = acc & ~sb;
        m_cond = (m_cond & ~acc) | (sb & acc);
        m_pend = acc | (m_pend & ~clr);
        e++;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".cond"}, a_cond, m_cond);
        chk({tag, ".pos"},  a_pos,  m_pos);
        chk({tag, ".neg"},  a_neg,  m_neg);
        chk({tag, ".pend"}, a_pend, m_pend);
    endtask

    // Called between edges; returns at the following negedge.
    task automatic step(input logic [3:0] nin, input logic [3:0] clr, input string tag);
        a_in  = nin;
        a_clr = clr;
        @(posedge clk);
        model_edge(nin, clr);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    // Called at a negedge; asserts reset asynchronously mid-cycle and releases it mid-cycle.
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        chk("rst_async.b", {b_cond, b_pos, b_neg, b_pend}, 4'b0000);
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] lvl;
        int         hit;

        reset_n = 1'b0;
        a_in    = '0;
        a_clr   = '0;
        b_in    = 1'b1;
        b_clr   = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        chk("reset.b", {b_cond, b_pos, b_neg, b_pend}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // ch0 rises before edge 0; B instance sees its input high from edge 0
        lvl = 4'b0001;
        hit = -1;
        for (int k = 0; k < 7; k++) begin
            step(lvl, 4'b0000, "rise0");
            if (a_pos[0] && hit < 0) hit = k;
            chk("b.cond", b_cond, (k >= 3) ? 1 : 0);
            chk("b.pos",  b_pos,  (k == 3) ? 1 : 0);
        end
        chk("lat_rise0", hit, 4);

        // ch1 bounce for 10 cycles then settles high at relative edge 10
        hit = -1;
        for (int k = 0; k < 18; k++) begin
            lvl[1] = (k >= 10) ? 1'b1 : ((k % 2) == 0);
            step(lvl, 4'b0000, "bounce1");
            if (a_pos[1] && hit < 0) hit = k;
        end
        chk("lat_bounce1", hit, 14);

        // ch2 glitch of two cycles
        for (int k = 0; k < 8; k++) begin
            lvl[2] = (k < 2);
            step(lvl, 4'b0000, "glitch2");
        end
        chk("glitch2.cond", a_cond[2], 1'b0);

        // clear racing a negativeedge on ch0
        step(lvl, 4'b0001, "pre_clr");
        lvl[0] = 1'b0;
        for (int k = 0; k < 4; k++) step(lvl, 4'b0000, "race0");
        step(lvl, 4'b0001, "race0_edge");
        chk("race0.neg",  a_neg[0],  1'b1);
        chk("race0.pend", a_pend[0], 1'b1);
        step(lvl, 4'b0001, "race0_clr");
        chk("race0.cleared", a_pend[0], 1'b0);

        // ch3 reset with count at 2 of 3, input stays high
        lvl[3] = 1'b1;
        for (int k = 0; k < 4; k++) step(lvl, 4'b0000, "mid3");
        pulse_reset();
        hit = -1;
        for (int k = 0; k < 7; k++) begin
            step(lvl, 4'b0000, "post_rst3");
            if (a_pos[3] && hit < 0) hit = k;
        end
        chk("lat_post_rst3", hit, 4);

        // random traffic: sticky levels with occasional flips, random clears, rare resets
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) lvl[i] = ~lvl[i];
            end
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset();
            end
            step(lvl, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, "rand");
            chk("rand.excl", a_pos & a_neg, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
